// File: rtl/bus_dma_pkg.sv
// bus_dma_pkg: shared definitions for initiators on the SoC bus.
//   ADDR_W_DEF / DATA_W_DEF : default bus address and data widths
//   ADDR_MASK               : mask of the 17-bit bus address space
//   bus_dma_state_t         : DMA channel FSM state encoding
// Also imported by the arbiter and any future bus initiator.
package bus_dma_pkg;

    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 8;

    localparam logic [ADDR_W_DEF-1:0] ADDR_MASK = 17'h1FFFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        WR   = 3'd4,
        FIN  = 3'd5
    } bus_dma_state_t;

endpackage

// File: rtl/bus_dma.sv
// bus_dma: single-channel DMA bus initiator. It copies length bytes from
// src_addr to dst_addr over the shared SoC bus, one byte per RD/CAP/WR
// sequence.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   start, abort        launch a transfer (idle only) / stop after current byte
//   src_addr, dst_addr  base addresses, sampled on an accepted start
//   length              byte count, sampled on an accepted start (0 = no bus cycles)
//   busy, done          transfer in progress / one-cycle completion pulse
//   bus_req, bus_gnt    arbiter request / grant
//   bus_addr, bus_we    bus address and write enable
//   bus_dout, bus_din   write data / registered read data (valid the cycle after address)
//   state               current FSM state, for observation
//
// Optional build macro BUS_DMA_FILL_EN adds fill_mode/fill_byte. With fill_mode=1
// every byte is a single WR cycle of fill_byte and the source is never read.
//
// Bus handshake: bus_req is held high from REQ through WR. Grant is only looked
// at in REQ and at the end of each WR (byte boundary). Once a byte has started,
// it always runs to completion even if bus_gnt falls.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
`ifdef BUS_DMA_FILL_EN
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_byte,
`endif
    output logic              busy,
    output logic              done,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din,
    output bus_dma_state_t    state
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              abort_q;
`ifdef BUS_DMA_FILL_EN
    logic              fill_q;
    logic [DATA_W-1:0] fill_byte_q;
`endif

    logic [ADDR_W-1:0] src_nxt;
    logic [ADDR_W-1:0] dst_nxt;
    logic              stop_now;

    // Address counters wrap naturally at the top of the ADDR_W space.
    assign src_nxt  = src_q + 1'b1;
    assign dst_nxt  = dst_q + 1'b1;
    // End the transfer at the end of this WR: last byte, or an abort seen now or earlier.
    assign stop_now = (cnt_q == ADDR_W'(1)) || abort_q || abort;

    // All outputs are registered and updated alongside the state transition,
    // so each reflects the state it belongs to during that state's cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bus_req  <= 1'b0;
            bus_addr <= '0;
            bus_we   <= 1'b0;
            bus_dout <= '0;
`ifdef BUS_DMA_FILL_EN
            fill_q      <= 1'b0;
            fill_byte_q <= '0;
`endif
        end else begin
            done <= 1'b0;
            // Sticky abort; in IDLE an abort is ignored, even alongside start.
            if (state != IDLE) begin
                abort_q <= abort_q | abort;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        cnt_q   <= length;
                        abort_q <= 1'b0;
                        busy    <= 1'b1;
`ifdef BUS_DMA_FILL_EN
                        fill_q      <= fill_mode;
                        fill_byte_q <= fill_byte;
`endif
                        if (length == '0) begin
                            state <= FIN;
                        end else begin
                            state   <= REQ;
                            bus_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (abort_q || abort) begin
                        state   <= FIN;
                        bus_req <= 1'b0;
                    end else if (bus_gnt) begin
`ifdef BUS_DMA_FILL_EN
                        if (fill_q) begin
                            state    <= WR;
                            bus_addr <= dst_q;
                            bus_we   <= 1'b1;
                            bus_dout <= fill_byte_q;
                        end else
`endif
                        begin
                            state    <= RD;
                            bus_addr <= src_q;
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    // Read data for the RD address arrives this cycle.
                    bus_dout <= bus_din;
                    bus_addr <= dst_q;
                    bus_we   <= 1'b1;
                    state    <= WR;
                end
                WR: begin
                    src_q <= src_nxt;
                    dst_q <= dst_nxt;
                    cnt_q <= cnt_q - 1'b1;
                    if (stop_now) begin
                        state   <= FIN;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                    end else if (bus_gnt) begin
`ifdef BUS_DMA_FILL_EN
                        if (fill_q) begin
                            bus_addr <= dst_nxt;
                        end else
`endif
                        begin
                            state    <= RD;
                            bus_addr <= src_nxt;
                            bus_we   <= 1'b0;
                        end
                    end else begin
                        state  <= REQ;
                        bus_we <= 1'b0;
                    end
                end
                FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    abort_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
